// File: rtl/usr_seq_ctrl.sv
// usr_seq_ctrl: sequencing controller for an n-bit universal shift register.
// On a start request it issues one load followed by a programmed number of
// left or right shifts, with pause and abort, and reports busy/done status.
// Every output is a registered Moore output; nothing passes combinationally
// from an input to an output.
//
// A pause sampled at an edge takes effect on the sel of the following cycle.
// The counter decrements only at the end of a cycle that actually drove a
// shift code. This keeps the counter and the shift register in step.
module usr_seq_ctrl #(
    parameter int n = 8,
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_start,
    input  logic         i_dir,
    input  logic [W-1:0] i_count,
    input  logic         i_pause,
    input  logic         i_abort,
    output logic [1:0]   o_sel,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_shifts_left
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0]   SEL_HOLD = 2'b00;
    localparam logic [1:0]   SEL_LOAD = 2'b01;
    localparam logic [W-1:0] N_MAX    = W'(n);

    state_t       r_state;
    logic [1:0]   r_sel;
    logic         r_busy;
    logic         r_done;
    logic [W-1:0] r_cnt;
    logic         r_dir;
    logic [W-1:0] r_cntLatch;

    state_t       w_stateNext;
    logic [1:0]   w_selNext;
    logic         w_busyNext;
    logic         w_doneNext;
    logic [W-1:0] w_cntNext;
    logic         w_dirNext;
    logic [W-1:0] w_cntLatchNext;
    logic [W-1:0] w_countSat;
    logic [W-1:0] w_cntDec;
    logic [1:0]   w_shiftCode;

    // Next-state and next-output decode; outputs are computed for the next cycle.
    always_comb begin
        w_stateNext    = r_state;
        w_selNext      = SEL_HOLD;
        w_cntNext      = r_cnt;
        w_dirNext      = r_dir;
        w_cntLatchNext = r_cntLatch;
        w_countSat     = (i_count > N_MAX) ? N_MAX : i_count;
        w_cntDec       = (r_cnt != '0) ? (r_cnt - W'(1)) : r_cnt;
        w_shiftCode    = {1'b1, r_dir};

        case (r_state)
            IDLE: begin
                if (i_start && !i_abort) begin
                    w_stateNext    = LOAD;
                    w_selNext      = SEL_LOAD;
                    w_dirNext      = i_dir;
                    w_cntLatchNext = w_countSat;
                end
            end
            LOAD: begin
                if (i_abort) begin
                    w_stateNext = IDLE;
                end else if (r_cntLatch == '0) begin
                    w_stateNext = DONE;
                end else begin
                    w_stateNext = SHIFT;
                    w_cntNext   = r_cntLatch;
                    w_selNext   = w_shiftCode;
                end
            end
            SHIFT: begin
                if (i_abort) begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else if (r_sel[1]) begin
                    w_cntNext = w_cntDec;
                    if (w_cntDec == '0) begin
                        w_stateNext = DONE;
                    end else begin
                        w_selNext = i_pause ? SEL_HOLD : w_shiftCode;
                    end
                end else begin
                    w_selNext = i_pause ? SEL_HOLD : w_shiftCode;
                end
            end
            DONE: begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
            default: begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
        endcase

        w_busyNext = (w_stateNext != IDLE);
        w_doneNext = (w_stateNext == DONE);
    end

    // State, latched parameters and registered outputs, with synchronous clear.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state    <= IDLE;
            r_sel      <= SEL_HOLD;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cnt      <= '0;
            r_dir      <= 1'b0;
            r_cntLatch <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_sel      <= w_selNext;
            r_busy     <= w_busyNext;
            r_done     <= w_doneNext;
            r_cnt      <= w_cntNext;
            r_dir      <= w_dirNext;
            r_cntLatch <= w_cntLatchNext;
        end
    end

    assign o_sel         = r_sel;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_shifts_left = r_cnt;

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Testbench for usr_seq_ctrl.
// Each table row gives the inputs present at one rising edge and the outputs
// expected just after that edge. A small universal shift register model is
// driven by sel so that whole sequences can be checked against final data.
module tb_usr_seq_ctrl;

    localparam int N = 8;
    localparam int W = 4;

    logic         clk;
    logic         clr;
    logic         start;
    logic         dir;
    logic [W-1:0] count;
    logic         pause;
    logic         abort;
    logic [1:0]   sel;
    logic         busy;
    logic         done;
    logic [W-1:0] shiftsLeft;

    logic [N-1:0] shiftReg;
    logic [N-1:0] dataIn;
    logic         dbit;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string        name;
        logic         clr;
        logic         start;
        logic         dir;
        logic [W-1:0] count;
        logic         pause;
        logic         abort;
        logic [1:0]   expSel;
        logic         expBusy;
        logic         expDone;
        logic [W-1:0] expLeft;
    } vec_t;

    vec_t vecs[$];

    usr_seq_ctrl #(.n(N), .W(W)) dut (
        .i_clk         (clk),
        .i_clr         (clr),
        .i_start       (start),
        .i_dir         (dir),
        .i_count       (count),
        .i_pause       (pause),
        .i_abort       (abort),
        .o_sel         (sel),
        .o_busy        (busy),
        .o_done        (done),
        .o_shifts_left (shiftsLeft)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference universal shift register steered by the controller's sel.
    always_ff @(posedge clk) begin
        case (sel)
            2'b01:   shiftReg <= dataIn;
            2'b10:   shiftReg <= {shiftReg[N-2:0], dbit};
            2'b11:   shiftReg <= {dbit, shiftReg[N-1:1]};
            default: shiftReg <= shiftReg;
        endcase
    end

    // Appends one vector to the table.
    task automatic addVec(input string nm, input logic c, input logic s, input logic d,
                          input logic [W-1:0] cnt, input logic p, input logic a,
                          input logic [1:0] eSel, input logic eBusy, input logic eDone,
                          input logic [W-1:0] eLeft);
        vec_t v;
        v.name = nm; v.clr = c; v.start = s; v.dir = d; v.count = cnt;
        v.pause = p; v.abort = a; v.expSel = eSel; v.expBusy = eBusy;
        v.expDone = eDone; v.expLeft = eLeft;
        vecs.push_back(v);
    endtask

    // Drives one set of inputs and waits until just after the next rising edge.
    task automatic applyStimulus(input logic c, input logic s, input logic d,
                                 input logic [W-1:0] cnt, input logic p, input logic a);
        clr = c; start = s; dir = d; count = cnt; pause = p; abort = a;
        @(posedge clk);
        #1;
    endtask

    // Compares all four outputs against one expectation.
    task automatic checkOutput(input string nm, input logic [1:0] eSel, input logic eBusy,
                               input logic eDone, input logic [W-1:0] eLeft);
        checks++;
        if (sel !== eSel || busy !== eBusy || done !== eDone || shiftsLeft !== eLeft) begin
            errors++;
            $display("[TB] FAIL %s: got sel=%b busy=%b done=%b left=%0d, want sel=%b busy=%b done=%b left=%0d",
                     nm, sel, busy, done, shiftsLeft, eSel, eBusy, eDone, eLeft);
        end
    endtask

    // Runs one start-to-done sequence and checks the shift register contents at done.
    task automatic runDataSeq(input string nm, input logic d, input logic [W-1:0] cnt,
                              input logic [N-1:0] din, input int expShifts,
                              input logic [N-1:0] expData);
        int shiftCycles = 0;
        bit seenDone = 0;
        dataIn = din;
        dbit   = 1'b0;
        applyStimulus(1'b0, 1'b1, d, cnt, 1'b0, 1'b0);
        for (int k = 0; k < 40 && !seenDone; k++) begin
            applyStimulus(1'b0, 1'b0, ~d, 4'd1, 1'b0, 1'b0);
            if (sel[1]) shiftCycles++;
            if (done) seenDone = 1;
        end
        checks++;
        if (!seenDone) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got no done within 40 cycles, want done", nm);
        end
        checks++;
        if (shiftCycles != expShifts) begin
            errors++;
            $display("[TB] FAIL %s_shifts: got %0d shift cycles, want %0d", nm, shiftCycles, expShifts);
        end
        checks++;
        if (shiftReg !== expData) begin
            errors++;
            $display("[TB] FAIL %s_data: got %h, want %h", nm, shiftReg, expData);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; dir = 1'b0; count = '0; pause = 1'b0; abort = 1'b0;
        dataIn = '0; dbit = 1'b0;

        // Reset held with start asserted, then released.
        addVec("rst0",   1, 1, 0, 4'd3, 0, 0, 2'b00, 0, 0, 4'd0);
        addVec("rst1",   1, 1, 0, 4'd3, 0, 0, 2'b00, 0, 0, 4'd0);
        addVec("rstrel", 0, 0, 0, 4'd0, 0, 0, 2'b00, 0, 0, 4'd0);
        // Basic shift left by 3.
        addVec("l3_load", 0, 1, 0, 4'd3, 0, 0, 2'b01, 1, 0, 4'd0);
        addVec("l3_sh3",  0, 0, 0, 4'd0, 0, 0, 2'b10, 1, 0, 4'd3);
        addVec("l3_sh2",  0, 0, 0, 4'd0, 0, 0, 2'b10, 1, 0, 4'd2);
        addVec("l3_sh1",  0, 0, 0, 4'd0, 0, 0, 2'b10, 1, 0, 4'd1);
        addVec("l3_done", 0, 0, 0, 4'd0, 0, 0, 2'b00, 1, 1, 4'd0);
        addVec("l3_idle", 0, 0, 0, 4'd0, 0, 0, 2'b00, 0, 0, 4'd0);
        // Back-to-back: saturated right shift, with later dir/count/start changes ignored.
        addVec("r8_load", 0, 1, 1, 4'd15, 0, 0, 2'b01, 1, 0, 4'd0);
        addVec("r8_sh8",  0, 0, 0, 4'd2,  0, 0, 2'b11, 1, 0, 4'd8);
        addVec("r8_sh7",  0, 1, 0, 4'd1,  0, 0, 2'b11, 1, 0, 4'd7);
        addVec("r8_sh6",  0, 1, 0, 4'd1,  0, 0, 2'b11, 1, 0, 4'd6);
        addVec("r8_sh5",  0, 0, 0, 4'd0,  0, 0, 2'b11, 1, 0, 4'd5);
        addVec("r8_sh4",  0, 0, 0, 4'd0,  0, 0, 2'b11, 1, 0, 4'd4);
        addVec("r8_sh3",  0, 0, 0, 4'd0,  0, 0, 2'b11, 1, 0, 4'd3);
        addVec("r8_sh2",  0, 0, 0, 4'd0,  0, 0, 2'b11, 1, 0, 4'd2);
        addVec("r8_sh1",  0, 0, 0, 4'd0,  0, 0, 2'b11, 1, 0, 4'd1);
        addVec("r8_done", 0, 0, 0, 4'd0,  0, 0, 2'b00, 1, 1, 4'd0);
        addVec("r8_idle", 0, 0, 0, 4'd0,  0, 0, 2'b00, 0, 0, 4'd0);
        // Zero count: load then done.
        addVec("z_load", 0, 1, 0, 4'd0, 0, 0, 2'b01, 1, 0, 4'd0);
        addVec("z_done", 0, 0, 0, 4'd0, 0, 0, 2'b00, 1, 1, 4'd0);
        addVec("z_idle", 0, 0, 0, 4'd0, 0, 0, 2'b00, 0, 0, 4'd0);
        // Count 4 with two pause cycles; pause in LOAD is ignored.
        addVec("p_load",  0, 1, 0, 4'd4, 0, 0, 2'b01, 1, 0, 4'd0);
        addVec("p_sh4",   0, 0, 0, 4'd0, 1, 0, 2'b10, 1, 0, 4'd4);
        addVec("p_hold1", 0, 0, 0, 4'd0, 1, 0, 2'b00, 1, 0, 4'd3);
        addVec("p_hold2", 0, 0, 0, 4'd0, 1, 0, 2'b00, 1, 0, 4'd3);
        addVec("p_sh3",   0, 0, 0, 4'd0, 0, 0, 2'b10, 1, 0, 4'd3);
        addVec("p_sh2",   0, 0, 0, 4'd0, 0, 0, 2'b10, 1, 0, 4'd2);
        addVec("p_sh1",   0, 0, 0, 4'd0, 0, 0, 2'b10, 1, 0, 4'd1);
        addVec("p_done",  0, 0, 0, 4'd0, 0, 0, 2'b00, 1, 1, 4'd0);
        addVec("p_idle",  0, 0, 0, 4'd0, 0, 0, 2'b00, 0, 0, 4'd0);
        // Abort (together with pause) in the second SHIFT cycle of count 5.
        addVec("a_load",  0, 1, 0, 4'd5, 0, 0, 2'b01, 1, 0, 4'd0);
        addVec("a_sh5",   0, 0, 0, 4'd0, 0, 0, 2'b10, 1, 0, 4'd5);
        addVec("a_sh4",   0, 0, 0, 4'd0, 0, 0, 2'b10, 1, 0, 4'd4);
        addVec("a_abort", 0, 0, 0, 4'd0, 1, 1, 2'b00, 0, 0, 4'd0);
        addVec("a_idle",  0, 0, 0, 4'd0, 0, 0, 2'b00, 0, 0, 4'd0);
        // Start together with abort in IDLE stays IDLE.
        addVec("sa_idle0", 0, 1, 0, 4'd3, 0, 1, 2'b00, 0, 0, 4'd0);
        addVec("sa_idle1", 0, 0, 0, 4'd0, 0, 0, 2'b00, 0, 0, 4'd0);
        // Abort in LOAD.
        addVec("al_load", 0, 1, 1, 4'd2, 0, 0, 2'b01, 1, 0, 4'd0);
        addVec("al_idle", 0, 0, 0, 4'd0, 0, 1, 2'b00, 0, 0, 4'd0);
        // Abort during DONE: done still seen, then IDLE.
        addVec("ad_load", 0, 1, 0, 4'd0, 0, 0, 2'b01, 1, 0, 4'd0);
        addVec("ad_done", 0, 0, 0, 4'd0, 0, 0, 2'b00, 1, 1, 4'd0);
        addVec("ad_idle", 0, 0, 0, 4'd0, 0, 1, 2'b00, 0, 0, 4'd0);
        // Clear mid-sequence: no done afterwards.
        addVec("c_load",  0, 1, 1, 4'd3, 0, 0, 2'b01, 1, 0, 4'd0);
        addVec("c_sh3",   0, 0, 0, 4'd0, 0, 0, 2'b11, 1, 0, 4'd3);
        addVec("c_clr",   1, 0, 0, 4'd0, 0, 0, 2'b00, 0, 0, 4'd0);
        addVec("c_idle0", 0, 0, 0, 4'd0, 0, 0, 2'b00, 0, 0, 4'd0);
        addVec("c_idle1", 0, 0, 0, 4'd0, 0, 0, 2'b00, 0, 0, 4'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].clr, vecs[i].start, vecs[i].dir, vecs[i].count,
                          vecs[i].pause, vecs[i].abort);
            checkOutput(vecs[i].name, vecs[i].expSel, vecs[i].expBusy,
                        vecs[i].expDone, vecs[i].expLeft);
        end

        // Data path sequences through the reference shift register.
        runDataSeq("dataL3", 1'b0, 4'd3,  8'hA5, 3, 8'h28);
        runDataSeq("dataR8", 1'b1, 4'd15, 8'h80, 8, 8'h00);
        runDataSeq("dataR2", 1'b1, 4'd2,  8'hC3, 2, 8'h30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usr_seq_ctrl.md
# usr_seq_ctrl

Sequencing controller for the n-bit universal shift register. On a start request it drives the register's 2-bit `sel` to perform one load and then a programmed number of left or right shifts, with pause and abort support. It sits between the control FSM or bus interface and the shift register, and reports busy/done status.

## Interface

**Parameters**
- `n`, 8: width of the controlled shift register; the maximum shift count.
- `W`, 4: width of the count input and the counter; must satisfy 2^W − 1 ≥ n.

**Ports**
- `clk`, input, 1: clock; all state changes on its rising edge.
- `clr`, input, 1: synchronous, active-high reset; it has priority over every other input.
- `start`, input, 1: request a load-and-shift sequence; sampled only in IDLE.
- `dir`, input, 1: shift direction, latched with `start`. 0 = shift left (`sel`=10); 1 = shift right (`sel`=11).
- `count`, input, W: number of shifts, latched with `start`. Values above `n` saturate to `n`.
- `pause`, input, 1: while high in SHIFT, drive hold and freeze the counter.
- `abort`, input, 1: terminate any active sequence; return to IDLE with no done pulse.
- `sel`, output, 2: select code for the shift register. 00 = hold, 01 = load, 10 = shift left, 11 = shift right.
- `busy`, output, 1: high in LOAD, SHIFT and DONE.
- `done`, output, 1: one-cycle pulse on normal completion.
- `shifts_left`, output, W: remaining shifts; 0 outside SHIFT.

## Operation

**Outputs.** All outputs are registered Moore outputs decoded from the state; there is no combinational path from input to output.

**States:** IDLE, LOAD, SHIFT, DONE.
- **IDLE:** `sel`=00, `busy`=0, `done`=0.
  - `start`=1 and `abort`=0: latch `dir` and the saturated `count`, then go to LOAD.
- **LOAD:** one cycle; `sel`=01, `busy`=1.
  - Latched count of 0: go to DONE.
  - Otherwise: go to SHIFT, with counter and `shifts_left` = latched count.
  - `pause` is ignored in LOAD.
- **SHIFT:**
  - `pause`=0: `sel` = {1, latched `dir`}, and the counter decrements each cycle.
  - `pause`=1: `sel`=00 and the counter is held.
  - The state exits to DONE on the cycle after the last shift, when the counter reaches 0.
- **DONE:** one cycle; `sel`=00, `busy`=1, `done`=1. Then go to IDLE.

**Abort.** `abort`=1 in LOAD, SHIFT or DONE forces IDLE on the next edge. After that edge, `sel`=00, `done`=0 and `shifts_left`=0. `abort` has priority over `pause`.

**Ignored inputs.**
- `start` outside IDLE is ignored and is not queued.
- Changes to `dir`/`count` after latching have no effect.

**Simultaneous events.**
- `start` and `abort` together in IDLE: `abort` wins; stay in IDLE.
- `abort` in the DONE cycle: `done` is still 1 in that cycle (the state is already DONE); next state IDLE.

**Arithmetic.**
- The counter is W bits wide and only decrements while it is non-zero.
- Saturation uses an unsigned compare: `count` > `n` loads `n`.

## Timing

- `start` is sampled high at the end of cycle 0.
  - Cycle 1: LOAD (`sel`=01).
  - Cycles 2 … c+1: SHIFT. These are unpaused cycles; each paused cycle adds one.
  - Cycle c+2: DONE.
  - Cycle c+3: IDLE.
- Total latency from start to `done` is c+2 cycles, plus the number of pause cycles.
- The earliest restart is `start` sampled in the first IDLE cycle, which gives back-to-back sequences with one IDLE cycle between them.
- **Reset:**
  - `clr`=1 at any edge forces IDLE on that edge.
  - Values after that edge: `sel`=00, `busy`=0, `done`=0, `shifts_left`=0, and the latched `dir`/`count` cleared to 0.
  - Reset mid-sequence produces no `done`.

## Test plan

- **Reset:** `clr`=1 for 2 cycles with `start`=1 → `sel`=00, `busy`=0, `done`=0, `shifts_left`=0 throughout; `clr` released → IDLE.
- **Basic shift left:** `start`, `dir`=0, `count`=3 →
  - `sel` sequence 01, 10, 10, 10, 00.
  - `done`=1 only in the fifth cycle.
  - `shifts_left` = 3, 2, 1 in the SHIFT cycles.
  - With the register's data_in = 8'hA5 and dbit=0, the register ends at 8'h28.
- **Saturation and right shift:** `count`=15, `n`=8, `dir`=1 → exactly 8 cycles of `sel`=11 after the load, then `done`; a register loaded with 8'h80 and dbit=0 ends at 8'h00.
- **Zero count and pause:**
  - `count`=0 → `sel` 01 then 00, with `done` in cycle 2.
  - `count`=4 with `pause` high for 2 cycles mid-SHIFT → `sel`=00 during the pause, `shifts_left` frozen, `done` at cycle 8.
- **Abort and ignored start:**
  - `abort` in the second SHIFT cycle of `count`=5 → IDLE on the next edge, no `done`.
  - `start` during SHIFT → ignored, and the sequence length is unchanged.
  - `start`+`abort` in IDLE → remains IDLE.
- **Back-to-back:** a second `start` in the first IDLE after `done` → a new LOAD two cycles after the `done` pulse.
